// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RISC-V simple datapath.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared
// memory port with a ready handshake. It also provides a memory-wait timeout,
// an illegal-opcode trap and a retired-instruction counter.
// Optional feature macro: MC_JUMP_EN (adds JAL support and drives jump).
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | post-reset, moves to FETCH next cycle
// FETCH  | instruction read from PC, waits for mem_ready
// DECODE | opcode latched into op_q, legality check
// EXEC   | ALU operand/operation select, BEQ resolves here
// MEM    | data read (LW) or write (SW), waits for mem_ready
// WB     | register-file writeback
// TRAP   | absorbing error state (illegal opcode or timeout)

module multicycle_control #(
    parameter int ALU_OP_W    = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_addr_src,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                jump,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                busy,
    output logic                illegal,
    output logic                timeout,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_I   = 7'b0010011;
`ifdef MC_JUMP_EN
    localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = '0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2);

    // wait_cnt holds the number of wait cycles already seen; the cycle that
    // would make it reach MEM_TIMEOUT (with mem_ready still low) traps.
    localparam int  WAIT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int  WAIT_LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic TO_EN      = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_LAST_I[WAIT_W-1:0];
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            state;
    state_t            state_n;
    logic [6:0]        op_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;
    logic              set_illegal;
    logic              set_timeout;
    logic              retire;

    function automatic logic op_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_I: op_supported = 1'b1;
`ifdef MC_JUMP_EN
            OP_JAL:                           op_supported = 1'b1;
`endif
            default:                          op_supported = 1'b0;
        endcase
    endfunction

    assign wait_hit = TO_EN && !mem_ready && (wait_cnt == WAIT_LAST);

    // State register plus opcode latch, wait counter, sticky flags, retire count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            wait_cnt    <= '0;
            illegal     <= 1'b0;
            timeout     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_n;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
            if ((state_n != state) && ((state_n == S_FETCH) || (state_n == S_MEM))) begin
                wait_cnt <= '0;
            end else if (TO_EN && ((state == S_FETCH) || (state == S_MEM)) && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_ONE;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_timeout) begin
                timeout <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_ONE;
            end
        end
    end

    // Next-state logic with trap and retire qualifiers.
    always_comb begin
        state_n     = state;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        retire      = 1'b0;
        case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_n = S_DECODE;
                end else if (wait_hit) begin
                    state_n     = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                if (op_supported(opcode)) begin
                    state_n = S_EXEC;
                end else begin
                    state_n     = S_TRAP;
                    set_illegal = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I:   state_n = S_WB;
                    OP_LW, OP_SW: state_n = S_MEM;
                    OP_BEQ: begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                    end
`ifdef MC_JUMP_EN
                    OP_JAL:       state_n = S_WB;
`endif
                    default:      state_n = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_n = S_WB;
                    end else begin
                        state_n = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (wait_hit) begin
                    state_n     = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_WB: begin
                state_n = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:  state_n = S_TRAP;
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath controls decoded from state, op_q and mem_ready.
    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_src = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        busy         = (state != S_IDLE) && (state != S_TRAP);
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: alu_op = ALU_FUNCT;
                    OP_I: begin
                        alu_src = 1'b1;
                        alu_op  = ALU_FUNCT;
                    end
                    OP_LW, OP_SW: alu_src = 1'b1;
                    OP_BEQ: begin
                        alu_op = ALU_SUB;
                        branch = 1'b1;
                    end
`ifdef MC_JUMP_EN
                    OP_JAL: jump = 1'b1;
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_addr_src = 1'b1;
                mem_read     = (op_q == OP_LW);
                mem_write    = (op_q == OP_SW);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LW);
            end
            default: ;
        endcase
    end

endmodule
